// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU ops, immediate formats and the
// ID->EX payload bundle.
package rv_pkg;

  localparam int unsigned RvXlen = 32;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_t;

  typedef enum logic [2:0] {ImmR, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_t;

  typedef struct packed {
    logic [RvXlen-1:0] pc;
    logic [RvXlen-1:0] rs1_data;
    logic [RvXlen-1:0] rs2_data;
    logic [RvXlen-1:0] imm;
    logic [4:0]        rd;
    logic              rd_we;
    alu_op_t           alu_op;
    logic              src1_pc;
    logic              src2_imm;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
    logic              branch;
    logic              jump;
    logic              illegal;
  } ex_payload_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_t fmt);
    case (fmt)
      ImmI:    imm_gen = {{20{ins[31]}}, ins[31:20]};
      ImmS:    imm_gen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ImmB:    imm_gen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ImmU:    imm_gen = {ins[31:12], 12'b0};
      ImmJ:    imm_gen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm_gen = '0;
    endcase
  endfunction

  // alt is instr[30]; it selects SUB only for register-register ops, SRA for both.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
    case (f3)
      3'b000:  alu_from_f3 = (alt && is_reg) ? AluSub : AluAdd;
      3'b001:  alu_from_f3 = AluSll;
      3'b010:  alu_from_f3 = AluSlt;
      3'b011:  alu_from_f3 = AluSltu;
      3'b100:  alu_from_f3 = AluXor;
      3'b101:  alu_from_f3 = alt ? AluSra : AluSrl;
      3'b110:  alu_from_f3 = AluOr;
      default: alu_from_f3 = AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch->ID, ID->EX and writeback signals of the decode stage.
// slave is the decode stage itself; master is its surroundings.
interface id_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            id_pipe_valid;
  logic            id_pipe_ready;
  logic            id_pipe_flush;
  logic [XLEN-1:0] id_pipe_pc;
  logic [XLEN-1:0] id_pipe_instruction;
  logic            ex_branch;
  logic            ex_pipe_valid;
  logic            ex_pipe_ready;
  logic [XLEN-1:0] ex_pipe_pc;
  logic [XLEN-1:0] ex_pipe_rs1_data;
  logic [XLEN-1:0] ex_pipe_rs2_data;
  logic [XLEN-1:0] ex_pipe_imm;
  logic [4:0]      ex_pipe_rd;
  logic            ex_pipe_rd_we;
  logic [3:0]      ex_pipe_alu_op;
  logic            ex_pipe_src1_pc;
  logic            ex_pipe_src2_imm;
  logic            ex_pipe_mem_read;
  logic            ex_pipe_mem_write;
  logic [2:0]      ex_pipe_funct3;
  logic            ex_pipe_branch;
  logic            ex_pipe_jump;
  logic            ex_pipe_illegal;
  logic            wb_rd_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_rd_data;

  modport master (
    output id_pipe_valid, id_pipe_pc, id_pipe_instruction, ex_branch, ex_pipe_ready,
           wb_rd_we, wb_rd, wb_rd_data,
    input  id_pipe_ready, id_pipe_flush, ex_pipe_valid, ex_pipe_pc, ex_pipe_rs1_data,
           ex_pipe_rs2_data, ex_pipe_imm, ex_pipe_rd, ex_pipe_rd_we, ex_pipe_alu_op,
           ex_pipe_src1_pc, ex_pipe_src2_imm, ex_pipe_mem_read, ex_pipe_mem_write,
           ex_pipe_funct3, ex_pipe_branch, ex_pipe_jump, ex_pipe_illegal
  );

  modport slave (
    input  id_pipe_valid, id_pipe_pc, id_pipe_instruction, ex_branch, ex_pipe_ready,
           wb_rd_we, wb_rd, wb_rd_data,
    output id_pipe_ready, id_pipe_flush, ex_pipe_valid, ex_pipe_pc, ex_pipe_rs1_data,
           ex_pipe_rs2_data, ex_pipe_imm, ex_pipe_rd, ex_pipe_rd_we, ex_pipe_alu_op,
           ex_pipe_src1_pc, ex_pipe_src2_imm, ex_pipe_mem_read, ex_pipe_mem_write,
           ex_pipe_funct3, ex_pipe_branch, ex_pipe_jump, ex_pipe_illegal
  );
endinterface

// File: rtl/regfile.sv
// 32-entry integer register file: two asynchronous read ports, one write port.
// x0 reads as zero and ignores writes.
module regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);
  logic [XLEN-1:0] mem_q [32];
  logic [XLEN-1:0] mem_d [32];

  always_comb begin
    for (int i = 0; i < 32; i++) mem_d[i] = mem_q[i];
    if (we_i && waddr_i != 5'd0) mem_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : mem_q[raddr_b_i];
endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: decode, register read, scoreboard stall, EX stage register.
// Define ID_WB_BYPASS_EN to forward writeback data into operand read and the hazard check.
module id_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = RvXlen
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  logic [31:0] ins;
  logic [4:0]  rs1, rs2, rd;
  logic        use_rs1, use_rs2, rd_we_raw;
  imm_fmt_t    fmt;
  ex_payload_t dec;
  logic [XLEN-1:0] rf_rdata_a, rf_rdata_b, rs1_data, rs2_data;

  logic        ex_valid_q, ex_valid_d;
  ex_payload_t ex_q, ex_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] wb_mask, set_mask, pend_src;
  logic        hazard, advance, issue;

  assign ins = bus.id_pipe_instruction;
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  always_comb begin
    dec       = '0;
    fmt       = ImmR;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    rd_we_raw = 1'b0;
    dec.alu_op = AluAdd;
    dec.funct3 = ins[14:12];
    case (ins[6:0])
      OpLui:    begin fmt = ImmU; rd_we_raw = 1'b1; dec.alu_op = AluPassB; dec.src2_imm = 1'b1; end
      OpAuipc:  begin
        fmt = ImmU; rd_we_raw = 1'b1; dec.src1_pc = 1'b1; dec.src2_imm = 1'b1;
      end
      OpJal:    begin
        fmt = ImmJ; rd_we_raw = 1'b1; dec.src1_pc = 1'b1; dec.src2_imm = 1'b1; dec.jump = 1'b1;
      end
      OpJalr:   begin
        fmt = ImmI; use_rs1 = 1'b1; rd_we_raw = 1'b1; dec.src2_imm = 1'b1; dec.jump = 1'b1;
      end
      OpBranch: begin
        fmt = ImmB; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.alu_op = AluSub; dec.branch = 1'b1;
      end
      OpLoad:   begin
        fmt = ImmI; use_rs1 = 1'b1; rd_we_raw = 1'b1; dec.src2_imm = 1'b1; dec.mem_read = 1'b1;
      end
      OpStore:  begin
        fmt = ImmS; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.src2_imm = 1'b1; dec.mem_write = 1'b1;
      end
      OpImm:    begin
        fmt = ImmI; use_rs1 = 1'b1; rd_we_raw = 1'b1; dec.src2_imm = 1'b1;
        dec.alu_op = alu_from_f3(ins[14:12], ins[30], 1'b0);
      end
      OpReg:    begin
        fmt = ImmR; use_rs1 = 1'b1; use_rs2 = 1'b1; rd_we_raw = 1'b1;
        dec.alu_op = alu_from_f3(ins[14:12], ins[30], 1'b1);
      end
      // FENCE and SYSTEM pass down as no-ops without a destination.
      OpFence, OpSystem: begin fmt = ImmI; use_rs1 = 1'b1; end
      default:  dec.illegal = 1'b1;
    endcase
    dec.imm   = imm_gen(ins, fmt);
    dec.rd    = rd;
    dec.rd_we = rd_we_raw && (rd != 5'd0) && !dec.illegal;
    dec.pc       = bus.id_pipe_pc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
  end

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (rs1),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (rs2),
    .rdata_b_o (rf_rdata_b),
    .we_i      (bus.wb_rd_we),
    .waddr_i   (bus.wb_rd),
    .wdata_i   (bus.wb_rd_data)
  );

  assign wb_mask = bus.wb_rd_we ? (32'd1 << bus.wb_rd) : 32'd0;

`ifdef ID_WB_BYPASS_EN
  always_comb begin
    rs1_data = rf_rdata_a;
    rs2_data = rf_rdata_b;
    if (bus.wb_rd_we && bus.wb_rd == rs1 && rs1 != 5'd0) rs1_data = bus.wb_rd_data;
    if (bus.wb_rd_we && bus.wb_rd == rs2 && rs2 != 5'd0) rs2_data = bus.wb_rd_data;
  end
  assign pend_src = pending_q & ~wb_mask;
`else
  assign rs1_data = rf_rdata_a;
  assign rs2_data = rf_rdata_b;
  assign pend_src = pending_q;
`endif

  always_comb begin
    hazard = (use_rs1 && pend_src[rs1]) || (use_rs2 && pend_src[rs2]) ||
             (dec.rd_we && pending_q[rd]);
    advance = !ex_valid_q || bus.ex_pipe_ready;
    issue   = bus.id_pipe_valid && !hazard && !bus.ex_branch && advance;
    ex_valid_d = advance ? issue : ex_valid_q;
    ex_d       = issue ? dec : ex_q;
    set_mask   = (issue && dec.rd_we) ? (32'd1 << rd) : 32'd0;
    // Set after clear so a same-cycle issue wins; bit 0 (x0) is never tracked.
    pending_d  = ((pending_q & ~wb_mask) | set_mask) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      pending_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.id_pipe_flush     = bus.ex_branch;
  assign bus.id_pipe_ready     = !bus.id_pipe_valid || issue || bus.ex_branch;
  assign bus.ex_pipe_valid     = ex_valid_q;
  assign bus.ex_pipe_pc        = ex_q.pc;
  assign bus.ex_pipe_rs1_data  = ex_q.rs1_data;
  assign bus.ex_pipe_rs2_data  = ex_q.rs2_data;
  assign bus.ex_pipe_imm       = ex_q.imm;
  assign bus.ex_pipe_rd        = ex_q.rd;
  assign bus.ex_pipe_rd_we     = ex_q.rd_we;
  assign bus.ex_pipe_alu_op    = ex_q.alu_op;
  assign bus.ex_pipe_src1_pc   = ex_q.src1_pc;
  assign bus.ex_pipe_src2_imm  = ex_q.src2_imm;
  assign bus.ex_pipe_mem_read  = ex_q.mem_read;
  assign bus.ex_pipe_mem_write = ex_q.mem_write;
  assign bus.ex_pipe_funct3    = ex_q.funct3;
  assign bus.ex_pipe_branch    = ex_q.branch;
  assign bus.ex_pipe_jump      = ex_q.jump;
  assign bus.ex_pipe_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; honours ID_WB_BYPASS_EN for RAW timing.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] pend;

  localparam logic [31:0] InsAddiX1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] InsAddiX2 = 32'h0070_0113;  // addi x2,x0,7
  localparam logic [31:0] InsAddX3  = 32'h0010_81B3;  // add  x3,x1,x1
  localparam logic [31:0] InsLwX5   = 32'h0000_A283;  // lw   x5,0(x1)
  localparam logic [31:0] InsJal    = 32'hFFDF_F0EF;  // jal  x1,-4
  localparam logic [31:0] InsIll    = 32'h0000_00FF;  // opcode 0x7F, rd=x1

  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) bus ();

  id_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign pend = dut.pending_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.id_pipe_valid       = v;
    bus.id_pipe_pc          = pc;
    bus.id_pipe_instruction = ins;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_rd_we   = we;
    bus.wb_rd      = rd;
    bus.wb_rd_data = data;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    bus.ex_branch     = 1'b0;
    bus.ex_pipe_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_ex_valid", bus.ex_pipe_valid, 0);
    check_eq("rst_id_ready", bus.id_pipe_ready, 1);
    check_eq("rst_flush", bus.id_pipe_flush, 0);
    check_eq("rst_pending", pend, 0);
    check_eq("rst_imm", bus.ex_pipe_imm, 0);

    // Back-to-back independent issue
    drive(1'b1, 32'h0000_0010, InsAddiX1);
    #1 check_eq("b2b_ready", bus.id_pipe_ready, 1);
    step();
    check_eq("b2b_valid0", bus.ex_pipe_valid, 1);
    check_eq("b2b_imm0", bus.ex_pipe_imm, 5);
    check_eq("b2b_rd0", bus.ex_pipe_rd, 1);
    check_eq("b2b_rdwe0", bus.ex_pipe_rd_we, 1);
    check_eq("b2b_src2imm0", bus.ex_pipe_src2_imm, 1);
    check_eq("b2b_pc0", bus.ex_pipe_pc, 32'h10);
    drive(1'b1, 32'h0000_0014, InsAddiX2);
    step();
    check_eq("b2b_valid1", bus.ex_pipe_valid, 1);
    check_eq("b2b_imm1", bus.ex_pipe_imm, 7);
    check_eq("b2b_rd1", bus.ex_pipe_rd, 2);
    drive(1'b0, 32'h0, 32'h0);
    check_eq("b2b_pending", pend, 32'h6);

    // Retire x1/x2 with values that differ from the RAW writeback below
    wb(1'b1, 5'd1, 32'h11);
    step();
    wb(1'b1, 5'd2, 32'h22);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check_eq("wb_clear_pending", pend, 0);
    check_eq("idle_ex_valid", bus.ex_pipe_valid, 0);

    // RAW stall on x1
    drive(1'b1, 32'h0000_0020, InsAddiX1);
    step();
    check_eq("raw_prod_valid", bus.ex_pipe_valid, 1);
    drive(1'b1, 32'h0000_0024, InsAddX3);
    #1 check_eq("raw_stall_ready", bus.id_pipe_ready, 0);
    step();
    check_eq("raw_stall_valid_a", bus.ex_pipe_valid, 0);
    step();
    check_eq("raw_stall_valid_b", bus.ex_pipe_valid, 0);
    check_eq("raw_stall_pending", pend, 32'h2);
    wb(1'b1, 5'd1, 32'h5);
    #1;
`ifdef ID_WB_BYPASS_EN
    check_eq("raw_wb_ready", bus.id_pipe_ready, 1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check_eq("raw_issue_valid", bus.ex_pipe_valid, 1);
`else
    check_eq("raw_wb_ready", bus.id_pipe_ready, 0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check_eq("raw_wb_cycle_valid", bus.ex_pipe_valid, 0);
    #1 check_eq("raw_after_wb_ready", bus.id_pipe_ready, 1);
    step();
    check_eq("raw_issue_valid", bus.ex_pipe_valid, 1);
`endif
    drive(1'b0, 32'h0, 32'h0);
    check_eq("raw_rs1", bus.ex_pipe_rs1_data, 5);
    check_eq("raw_rs2", bus.ex_pipe_rs2_data, 5);
    check_eq("raw_rd", bus.ex_pipe_rd, 3);
    check_eq("raw_alu_add", bus.ex_pipe_alu_op, 0);
    check_eq("raw_pending", pend, 32'h8);

    // EX backpressure
    bus.ex_pipe_ready = 1'b0;
    drive(1'b1, 32'h0000_0028, InsAddiX2);
    #1 check_eq("bp_ready", bus.id_pipe_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("bp_valid_%0d", i), bus.ex_pipe_valid, 1);
      check_eq($sformatf("bp_rd_%0d", i), bus.ex_pipe_rd, 3);
      check_eq($sformatf("bp_rs1_%0d", i), bus.ex_pipe_rs1_data, 5);
      check_eq($sformatf("bp_pending_%0d", i), pend, 32'h8);
      check_eq($sformatf("bp_idready_%0d", i), bus.id_pipe_ready, 0);
    end
    bus.ex_pipe_ready = 1'b1;
    #1 check_eq("bp_release_ready", bus.id_pipe_ready, 1);
    step();
    check_eq("bp_next_rd", bus.ex_pipe_rd, 2);
    check_eq("bp_next_imm", bus.ex_pipe_imm, 7);
    drive(1'b0, 32'h0, 32'h0);
    check_eq("bp_pending_after", pend, 32'hC);

    // Flush while a load is presented
    drive(1'b1, 32'h0000_002C, InsLwX5);
    bus.ex_branch = 1'b1;
    #1;
    check_eq("fl_flush", bus.id_pipe_flush, 1);
    check_eq("fl_ready", bus.id_pipe_ready, 1);
    step();
    bus.ex_branch = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_eq("fl_ex_valid", bus.ex_pipe_valid, 0);
    check_eq("fl_pending", pend, 32'hC);
    #1 check_eq("fl_flush_off", bus.id_pipe_flush, 0);

    // Immediate / illegal decode
    drive(1'b1, 32'h0000_0100, InsJal);
    step();
    check_eq("jal_imm", bus.ex_pipe_imm, 32'hFFFF_FFFC);
    check_eq("jal_jump", bus.ex_pipe_jump, 1);
    check_eq("jal_src1pc", bus.ex_pipe_src1_pc, 1);
    check_eq("jal_pc", bus.ex_pipe_pc, 32'h100);
    check_eq("jal_rdwe", bus.ex_pipe_rd_we, 1);
    drive(1'b1, 32'h0000_0104, InsIll);
    step();
    check_eq("ill_valid", bus.ex_pipe_valid, 1);
    check_eq("ill_flag", bus.ex_pipe_illegal, 1);
    check_eq("ill_rdwe", bus.ex_pipe_rd_we, 0);

    // Asynchronous reset while stalled on x1
    drive(1'b1, 32'h0000_0108, InsAddX3);
    #1;
    check_eq("rs_stall_ready", bus.id_pipe_ready, 0);
    check_eq("rs_pre_pending", pend, 32'hE);
    #1 rst = 1'b1;
    #1;
    check_eq("rs_ex_valid", bus.ex_pipe_valid, 0);
    check_eq("rs_pending", pend, 0);
    check_eq("rs_illegal", bus.ex_pipe_illegal, 0);
    rst = 1'b0;
    #1 check_eq("rs_post_ready", bus.id_pipe_ready, 1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check_eq("rs_issue_valid", bus.ex_pipe_valid, 1);
    check_eq("rs_rs1", bus.ex_pipe_rs1_data, 0);
    check_eq("rs_rs2", bus.ex_pipe_rs2_data, 0);
    check_eq("rs_rd", bus.ex_pipe_rd, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction Decode stage of the RV32I pipeline, directly downstream of instruction fetch. It accepts one fetched instruction per cycle over the `id_pipe` valid/ready handshake and decodes it. It reads source operands from an internal register file, stalls on register hazards using a per-register pending scoreboard, and registers the decoded bundle into the `ex_pipe` stage register. It also drives the fetch-side flush when EX resolves a taken branch or jump.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `id_pipe_valid` in 1: fetched instruction valid.
- `id_pipe_ready` out 1: ID accepts or drops the current instruction this cycle.
- `id_pipe_flush` out 1: flush request to fetch.
- `id_pipe_pc` in XLEN: PC of the fetched instruction.
- `id_pipe_instruction` in XLEN: instruction word.
- `ex_branch` in 1: EX is redirecting the PC (jump or taken branch).
- `ex_pipe_valid` out 1: EX stage register valid.
- `ex_pipe_ready` in 1: EX can accept a new instruction.
- `ex_pipe_pc` out XLEN: PC of the issued instruction.
- `ex_pipe_rs1_data` out XLEN: source operand 1.
- `ex_pipe_rs2_data` out XLEN: source operand 2.
- `ex_pipe_imm` out XLEN: sign-extended immediate.
- `ex_pipe_rd` out 5: destination register index.
- `ex_pipe_rd_we` out 1: destination register write enable.
- `ex_pipe_alu_op` out 4: ALU operation.
- `ex_pipe_src1_pc` out 1: ALU source 1 selects the PC.
- `ex_pipe_src2_imm` out 1: ALU source 2 selects the immediate.
- `ex_pipe_mem_read` out 1: load.
- `ex_pipe_mem_write` out 1: store.
- `ex_pipe_funct3` out 3: raw funct3 field, carrying access size and branch condition.
- `ex_pipe_branch` out 1: conditional branch.
- `ex_pipe_jump` out 1: JAL or JALR.
- `ex_pipe_illegal` out 1: opcode is not RV32I.
- `wb_rd_we` in 1: writeback enable.
- `wb_rd` in 5: writeback register index.
- `wb_rd_data` in XLEN: writeback data.

## Operation
- **Flush output.** `id_pipe_flush = ex_branch`, combinational.
- **Decode.** Decode is combinational from `id_pipe_instruction`.
  - Immediate formats are I, S, B, U and J, always sign-extended from bit 31.
  - `rd_we` is forced to 0 when rd is x0 or the instruction is illegal.
- **Source usage.**
  - rs1 is used by all formats except U and J.
  - rs2 is used only by R, S and B.
- **Scoreboard.** `pending[31:1]` holds one bit per register.
  - A bit is set when an instruction with `rd_we` issues.
  - A bit is cleared when `wb_rd_we` writes that register.
  - If set and clear hit the same register in the same cycle, set wins.
- **Hazard.** `hazard` is true when any of the following holds:
  - a used rs1 has its `pending` bit set;
  - a used rs2 has its `pending` bit set;
  - rd (with `rd_we`) has its `pending` bit set (WAW).
- **Issue.** `issue = id_pipe_valid & ~hazard & ~ex_branch & (~ex_pipe_valid | ex_pipe_ready)`.
- **Ready.** `id_pipe_ready = ~id_pipe_valid | issue | ex_branch`. During a flush the instruction is accepted and discarded.
- **EX register update.** When `~ex_pipe_valid | ex_pipe_ready`:
  - `ex_pipe_valid <= issue`;
  - the payload loads whenever `issue` is true.
  - Otherwise all `ex_pipe_*` outputs hold.
- **Register file.**
  - Reads are asynchronous; writes happen on `clk`.
  - x0 always reads 0, and writes to x0 are ignored.
  - Without bypass, reading a register in the same cycle it is written returns the old value. The scoreboard stall guarantees this case never issues.

## Timing
- **Latency.** An accepted instruction appears on `ex_pipe_*` in the next cycle (1-cycle latency).
- **Throughput.** One instruction per cycle when there is no hazard.
- **Reset values.** All of the following are 0:
  - `ex_pipe_valid`, `pending`, every `ex_pipe_*` payload field and all registers.
  - `id_pipe_ready` resets to 1, since `id_pipe_valid` is 0 then.
- **Reset mid-operation.** An in-flight instruction is lost and the scoreboard clears.
- **RAW stall.** A dependent instruction stalls until the cycle after `wb_rd_we` for its source (the default build has no bypass).
- **Flush.** `ex_branch` blocks issue in the same cycle. Bits already set by issued instructions stay set until their writeback.
- **`ex_pipe_ready` low with `ex_pipe_valid` high.** The payload holds, `id_pipe_ready` is 0 (unless flushing), and no scoreboard bit is set.

## Configuration
- **`ID_WB_BYPASS_EN` defined:**
  - A source matching `wb_rd` while `wb_rd_we` is high reads `wb_rd_data` directly.
  - That source's `pending` bit is treated as clear for the hazard check in that cycle, so the dependent instruction issues in the writeback cycle.
- **`ID_WB_BYPASS_EN` undefined:** the dependent instruction issues one cycle after writeback.

## Structure
- **Package `rv_pkg`.**
  - Opcode constants.
  - ALU operation enum `alu_op_t`, 4 bits: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - Immediate-format enum.
- **Sub-module `regfile`.** 32×XLEN, two asynchronous read ports, one synchronous write port, asynchronous reset of the storage to 0.
- **Decoder.** Stays inline as an always_comb block.

## Test plan
- **Back-to-back independent issue.** `addi x1,x0,5` then `addi x2,x0,7` on consecutive cycles -> `ex_pipe_valid` high on both following cycles; `ex_pipe_imm` = 5, then 7; `pending[1]` and `pending[2]` set.
- **RAW stall.** `addi x1,x0,5`, then `add x3,x1,x1`; `wb_rd_we`=1, `wb_rd`=1, `wb_rd_data`=5 arrives 3 cycles later.
  - Without bypass: `add` issues the cycle after writeback with `rs1_data` = `rs2_data` = 5.
  - With `ID_WB_BYPASS_EN`: `add` issues in the writeback cycle.
- **EX backpressure.** Hold `ex_pipe_ready`=0 for 4 cycles with a valid instruction in EX -> payload stable, `id_pipe_ready`=0, no new pending bits.
- **Flush.** Assert `ex_branch` while `id_pipe_valid`=1 with `lw x5,0(x1)` -> `id_pipe_flush`=1, `id_pipe_ready`=1, `ex_pipe_valid`=0 next cycle, `pending[5]` unchanged.
- **Immediate decode.** `jal x1,-4` (0xFFDFF0EF) -> `ex_pipe_imm`=0xFFFFFFFC, `jump`=1, `src1_pc`=1. Opcode 0x7F -> `illegal`=1, `rd_we`=0.
- **Reset during stall.** Assert `rst` asynchronously while the pipe is stalled on x1 -> `ex_pipe_valid`=0 and `pending`=0 immediately; after release, an `x1` reader issues without stall and reads 0.
